// File: rtl/cpu64_rf_pkg.sv
// Shared types, defaults and the write-port priority resolver for the multi-port register file.
package cpu64_rf_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;
  // Upper bound on write ports handled by the priority resolver.
  localparam int unsigned MAX_WR    = 8;
  localparam int unsigned WSEL_W    = 3;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  typedef struct packed {
    logic              hit;
    logic [WSEL_W-1:0] port;
  } wr_sel_t;

  // Highest-numbered asserted hit wins; hit=0 when no port targets the index.
  function automatic wr_sel_t rf_win_port(input logic [MAX_WR-1:0] hits);
    wr_sel_t sel;
    sel = '0;
    for (int unsigned w = 0; w < MAX_WR; w++) begin
      if (hits[w]) begin
        sel.hit  = 1'b1;
        sel.port = WSEL_W'(w);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/cpu64_rf_scoreboard.sv
// Per-register busy bits for in-flight producers: issue sets, writeback clears, issue dominates.
module cpu64_rf_scoreboard
  import cpu64_rf_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_idx_i,
  input  logic [NUM_WR-1:0]    wr_eff_i,
  input  logic [NUM_WR*AW-1:0] wr_idx_i,
  input  logic [NUM_RD*AW-1:0] rd_idx_i,
  input  logic [NUM_RD-1:0]    rd_hit_i,
  output logic [NUM_RD-1:0]    rd_busy_ao
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: clear on writeback first, then a same-cycle issue re-marks the entry.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_eff_i[w]) busy_d[wr_idx_i[w*AW +: AW]] = 1'b0;
    end
    if (run_i && iss_en_i && !(ZERO_REG && (iss_idx_i == '0))) begin
      busy_d[iss_idx_i] = 1'b1;
    end
  end

  // Busy state register, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Read lookup; a same-cycle write to the index hides the stale busy bit.
  always_comb begin
    rd_busy_ao = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_busy_ao[p] = run_i && busy_q[rd_idx_i[p*AW +: AW]] && !rd_hit_i[p];
    end
  end

endmodule

// File: rtl/cpu64_register_file_mp.sv
// Multi-port integer register file with write bypass, busy scoreboard and post-reset clearing sweep.
module cpu64_register_file_mp
  import cpu64_rf_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   ready_o,
  input  logic [NUM_RD*AW-1:0]   rd_idx_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_ao,
  output logic [NUM_RD-1:0]      rd_busy_ao,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_idx_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_idx_i
);

  rf_state_e         state_q;
  logic [AW-1:0]     sweep_q;
  logic              run;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic [NUM_WR-1:0] wr_eff;
  logic [AW-1:0]     widx  [NUM_WR];
  logic [XLEN-1:0]   wdata [NUM_WR];

  logic [NUM_RD-1:0] rd_hit;
  logic [AW-1:0]     r_idx  [NUM_RD];
  logic [MAX_WR-1:0] r_hits [NUM_RD];
  wr_sel_t           r_sel  [NUM_RD];
  logic [XLEN-1:0]   r_data [NUM_RD];

  assign run = (state_q == RF_RUN);

  // Unpack write ports and qualify them: only in RUN, never to a hardwired zero entry.
  always_comb begin
    wr_eff = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      widx[w]   = wr_idx_i[w*AW +: AW];
      wdata[w]  = wr_data_i[w*XLEN +: XLEN];
      wr_eff[w] = run && wr_en_i[w] && !(ZERO_REG && (widx[w] == '0));
    end
  end

  // Clearing sweep: walk every writable entry once after reset, then stay in RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RF_INIT;
      ready_o <= 1'b0;
      sweep_q <= ZERO_REG ? AW'(1) : AW'(0);
    end else if (state_q == RF_INIT) begin
      sweep_q <= sweep_q + AW'(1);
      if (sweep_q == AW'(NREGS - 1)) begin
        state_q <= RF_RUN;
        ready_o <= 1'b1;
      end
    end
  end

  // Storage has no reset; the sweep zeroes it, then ascending port order lets the highest port win.
  always_ff @(posedge clk_i) begin
    if (state_q == RF_INIT) begin
      mem_q[sweep_q] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_eff[w]) mem_q[widx[w]] <= wdata[w];
      end
    end
  end

  // Combinational read with write-to-read bypass; zero during the sweep and for a hardwired x0.
  always_comb begin
    rd_data_ao = '0;
    rd_hit     = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      r_idx[p]  = rd_idx_i[p*AW +: AW];
      r_hits[p] = '0;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        r_hits[p][w] = wr_eff[w] && (widx[w] == r_idx[p]);
      end
      r_sel[p]  = rf_win_port(r_hits[p]);
      rd_hit[p] = r_sel[p].hit;
      r_data[p] = mem_q[r_idx[p]];
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (r_sel[p].hit && (r_sel[p].port == WSEL_W'(w))) r_data[p] = wdata[w];
      end
      if (!run || (ZERO_REG && (r_idx[p] == '0))) r_data[p] = '0;
      rd_data_ao[p*XLEN +: XLEN] = r_data[p];
    end
  end

  cpu64_rf_scoreboard #(
    .NREGS    (NREGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (run),
    .iss_en_i   (iss_en_i),
    .iss_idx_i  (iss_idx_i),
    .wr_eff_i   (wr_eff),
    .wr_idx_i   (wr_idx_i),
    .rd_idx_i   (rd_idx_i),
    .rd_hit_i   (rd_hit),
    .rd_busy_ao (rd_busy_ao)
  );

endmodule

// File: tb/tb_cpu64_register_file_mp.sv
// Randomized scoreboard bench: two register files (hardwired x0 and ordinary x0) share one stimulus stream.
module tb_cpu64_register_file_mp;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [9:0]     rd_idx_i = '0;
  logic [1:0]     wr_en_i = '0;
  logic [9:0]     wr_idx_i = '0;
  logic [127:0]   wr_data_i = '0;
  logic           iss_en_i = 1'b0;
  logic [4:0]     iss_idx_i = '0;

  logic           ready_a, ready_b;
  logic [127:0]   rd_data_a, rd_data_b;
  logic [1:0]     rd_busy_a, rd_busy_b;

  cpu64_register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .ready_o(ready_a), .rd_idx_i(rd_idx_i), .rd_data_ao(rd_data_a),
    .rd_busy_ao(rd_busy_a), .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .iss_en_i(iss_en_i), .iss_idx_i(iss_idx_i));

  cpu64_register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b0)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .ready_o(ready_b), .rd_idx_i(rd_idx_i), .rd_data_ao(rd_data_b),
    .rd_busy_ao(rd_busy_b), .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .iss_en_i(iss_en_i), .iss_idx_i(iss_idx_i));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]       rdy;
    logic [3:0][63:0] data;
    logic [3:0]       busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: architectural contents, busy flags and edges seen since reset, per instance.
  logic [63:0] m_mem  [2][NREGS];
  logic        m_busy [2][NREGS];
  int          m_cnt  [2];

  // Staged stimulus, applied to the DUT inside step().
  logic [1:0]   n_wr_en;
  logic [9:0]   n_wr_idx;
  logic [127:0] n_wr_data;
  logic         n_iss_en;
  logic [4:0]   n_iss_idx;
  logic [9:0]   n_rd_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int i = 0; i < NREGS; i++) begin
        m_mem[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
    end
  endtask

  // Predict outputs for the current inputs, queue them, then advance the model over the next edge.
  task automatic predict();
    exp_t e;
    bit   zr, rdy;
    int   len;
    logic [4:0]  idx, wi;
    logic [63:0] d;
    logic        b;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      zr  = (k == 0);
      len = zr ? NREGS - 1 : NREGS;
      rdy = (m_cnt[k] >= len);
      e.rdy[k] = rdy;
      for (int p = 0; p < 2; p++) begin
        idx = rd_idx_i[p*AW +: AW];
        d = '0;
        b = 1'b0;
        if (rdy && !(zr && idx == 0)) begin
          d = m_mem[k][idx];
          b = m_busy[k][idx];
          for (int w = 0; w < 2; w++) begin
            if (wr_en_i[w] && wr_idx_i[w*AW +: AW] == idx) begin
              d = wr_data_i[w*64 +: 64];
              b = 1'b0;
            end
          end
        end
        e.data[k*2+p] = d;
        e.busy[k*2+p] = b;
      end
      if (rdy) begin
        for (int w = 0; w < 2; w++) begin
          wi = wr_idx_i[w*AW +: AW];
          if (wr_en_i[w] && !(zr && wi == 0)) begin
            m_mem[k][wi]  = wr_data_i[w*64 +: 64];
            m_busy[k][wi] = 1'b0;
          end
        end
        if (iss_en_i && !(zr && iss_idx_i == 0)) m_busy[k][iss_idx_i] = 1'b1;
      end else begin
        m_cnt[k]++;
      end
    end
    q.push_back(e);
  endtask

  // One clock: apply staged inputs (optionally with an asynchronous reset pulse between edges).
  task automatic step(input bit do_rst);
    @(posedge clk_i);
    #2;
    wr_en_i   = n_wr_en;
    wr_idx_i  = n_wr_idx;
    wr_data_i = n_wr_data;
    iss_en_i  = n_iss_en;
    iss_idx_i = n_iss_idx;
    rd_idx_i  = n_rd_idx;
    if (do_rst) begin
      rst_i = 1'b1;
      model_reset();
      predict();
      #5 rst_i = 1'b0;
    end else begin
      predict();
    end
  endtask

  function automatic logic [4:0] rnd_idx();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
  endfunction

  task automatic stage(input logic [1:0] en, input logic [4:0] wi0, input logic [63:0] wd0,
                       input logic [4:0] wi1, input logic [63:0] wd1, input logic ie,
                       input logic [4:0] ii, input logic [4:0] r0, input logic [4:0] r1);
    n_wr_en   = en;
    n_wr_idx  = {wi1, wi0};
    n_wr_data = {wd1, wd0};
    n_iss_en  = ie;
    n_iss_idx = ii;
    n_rd_idx  = {r1, r0};
  endtask

  task automatic stage_rand();
    stage(2'($urandom_range(0, 3)), rnd_idx(), {$urandom, $urandom}, rnd_idx(), {$urandom, $urandom},
          1'($urandom_range(0, 1)), rnd_idx(), rnd_idx(), rnd_idx());
  endtask

  task automatic stage_read(input logic [4:0] r0, input logic [4:0] r1);
    stage(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0, r0, r1);
  endtask

  // Monitor: compare the queued prediction against the DUT half a cycle after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready_a", 64'(ready_a), 64'(e.rdy[0]));
        chk("ready_b", 64'(ready_b), 64'(e.rdy[1]));
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("data_a_p%0d", p), rd_data_a[p*64 +: 64], e.data[p]);
          chk($sformatf("data_b_p%0d", p), rd_data_b[p*64 +: 64], e.data[2+p]);
          chk($sformatf("busy_a_p%0d", p), 64'(rd_busy_a[p]), 64'(e.busy[p]));
          chk($sformatf("busy_b_p%0d", p), 64'(rd_busy_b[p]), 64'(e.busy[2+p]));
        end
      end
    end
  end

  initial begin
    model_reset();
    stage_read(5'd0, 5'd1);
    step(1'b1);
    // Sweep: reads must stay zero while ready rises after 31 / 32 edges.
    for (int i = 0; i < 34; i++) begin
      stage_rand();
      step(1'b0);
    end
    // Write x5 with same-cycle read (bypass), then read it back from the array.
    stage(2'b01, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd6);
    step(1'b0);
    stage_read(5'd5, 5'd5);
    step(1'b0);
    // x0: all-ones write plus issue; hardwired in dut_a, ordinary in dut_b.
    stage(2'b01, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    step(1'b0);
    stage_read(5'd0, 5'd1);
    step(1'b0);
    // Both ports write x7: port 1 wins in bypass and in the array.
    stage(2'b11, 5'd7, 64'h11, 5'd7, 64'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    step(1'b0);
    stage_read(5'd7, 5'd0);
    step(1'b0);
    // Scoreboard: issue, read busy, clearing write, issue+write together.
    stage(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd9);
    step(1'b0);
    stage_read(5'd9, 5'd9);
    step(1'b0);
    stage(2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd9);
    step(1'b0);
    stage_read(5'd9, 5'd9);
    step(1'b0);
    stage(2'b10, 5'd0, 64'd0, 5'd9, 64'h9A, 1'b1, 5'd9, 5'd9, 5'd9);
    step(1'b0);
    stage_read(5'd9, 5'd9);
    step(1'b0);
    // Reset mid-RUN with x3 busy, then a full sweep.
    stage(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 5'd9);
    step(1'b0);
    stage_read(5'd3, 5'd9);
    step(1'b0);
    step(1'b1);
    for (int i = 0; i < 34; i++) begin
      stage_read(5'd3, 5'($urandom_range(0, 31)));
      step(1'b0);
    end
    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      stage_rand();
      step($urandom_range(0, 149) == 0);
    end
    stage_read(5'd0, 5'd0);
    repeat (3) @(posedge clk_i);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL queue_drain actual=%0d expected=0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
